pseudo_sensor_axis_src: RTL
===========================

# pseudo_sensor_axis_src

Parametrised pseudo-sensor frame source for the pseudo-sensor subsystem. It raster-scans a bank of N_IMAGES synchronous image ROMs and streams pixels to the LeNet-5 core as an AXI4-Stream video stream, with backpressure. It generalises the fixed 640x480 / 10-image VGA-paced source in three ways: the geometry, image count and blanking are parameters; image sequencing is selectable (cycle, hold, single-step); and each image can be repeated for several frames. It sits between the ROM mux and the core's stream input, and replaces the ping-pong frame buffer when no display is attached.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- H_BLANK, 160, idle cycles after each line except the last
- V_BLANK, 45, idle cycles after the last line
- ADDR_FRAME, 19, ROM address width; must satisfy 2^ADDR_FRAME >= H_ACTIVE*V_ACTIVE
- DATA_WIDTH, 8, pixel width
- N_IMAGES, 10, number of images; must be between 2 and 2^IMG_W
- IMG_W, 4, image index width

Ports:
- p_clk, in, 1, the block's single clock
- srst_p, in, 1, reset; synchronous, active-high
- enable, in, 1, run request
- mode, in, 2, image sequencing: 0 = cycle, 1 = hold, 2 = step, 3 = same as hold
- step, in, 1, single-cycle advance request, used in step mode
- repeat_cnt, in, 8, frames per image; 0 is treated as 1
- rom_addr, out, ADDR_FRAME, linear pixel address
- rom_sel, out, IMG_W, image select for the ROM mux
- rom_data, in, DATA_WIDTH, ROM read data, valid 1 cycle after rom_addr
- m_axis_tdata, out, DATA_WIDTH, pixel
- m_axis_tvalid, out, 1, output valid
- m_axis_tready, in, 1, downstream ready
- m_axis_tuser, out, 1, start of frame (pixel 0,0)
- m_axis_tlast, out, 1, end of line
- image_num, out, IMG_W, image currently being streamed
- frame_done, out, 1, one-cycle pulse at each frame boundary
- busy, out, 1, high when the FSM is not in IDLE

## Operation
- The FSM has four states: IDLE, LINE, HBLANK and VBLANK.
- IDLE -> LINE when enable=1. On entry, x, y and the address counter are cleared.
- In LINE, one ROM read is issued in each cycle where issue_ok is true.
  - issue_ok = (fifo_count + inflight) < 4. A pop in the same cycle is not credited.
  - An issue drives rom_addr = addr and rom_sel = image_num, then increments x and addr.
- Leaving LINE happens when the read with x = H_ACTIVE-1 is issued:
  - if y < V_ACTIVE-1, go to HBLANK;
  - otherwise go to VBLANK.
- HBLANK runs H_BLANK cycles, then y increments, x resets and the FSM returns to LINE. When H_BLANK=0, LINE continues directly on the next line.
- VBLANK runs V_BLANK cycles; its final cycle is the frame boundary. The blanking counters run regardless of tready.
- At the frame boundary:
  - frame_done is pulsed and frame_cnt increments.
  - If frame_cnt reaches max(repeat_cnt,1), frame_cnt is cleared and the image advances:
    - mode 0: image_num increments, wrapping from N_IMAGES-1 to 0;
    - mode 1 or 3: no change;
    - mode 2: increment (with wrap) only if step_pending is set, then clear step_pending.
  - The next state is LINE if enable=1, otherwise IDLE.
- step_pending is set by any step pulse and is held until it is consumed at a boundary.
- mode and repeat_cnt are sampled only at frame boundaries. Deasserting enable mid-frame finishes the current frame.
- Output FIFO:
  - 4 entries, each holding {data, tuser, tlast}.
  - Push: the cycle after an issue, capturing rom_data together with the tuser/tlast flags delayed from the issue.
  - Pop: tvalid & tready.
  - Overflow is impossible by the credit rule.
- Reset clears all state. FIFO and in-flight reads are discarded. image_num=0, frame_cnt=0, step_pending=0.

## Timing
- Reset values, in the cycle after srst_p: all outputs 0, state IDLE.
- Latency:
  - enable=1 sampled at edge 0 -> first rom_addr issued in cycle 1;
  - push at edge 2;
  - m_axis_tvalid=1 with tuser=1 in cycle 3 (3 cycles after enable).
- Throughput: 1 pixel per cycle sustained while tready=1. With tready held low, at most 4 reads are outstanding and issue stalls.
- tdata, tuser and tlast are held stable while tvalid=1 and tready=0.
- rom_sel changes only at frame boundaries, so it never changes mid-frame.
- image_num updates on the clock edge after the boundary cycle, in the same cycle that the first read of the next frame is issued.
- Frame length with tready=1 is V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK cycles.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3, N_IMAGES=3, unless stated otherwise.
- Reset/latency: release srst_p, set enable=1 with tready=1 -> tvalid first high 3 cycles after enable, with tuser=1 and tdata = ROM0[0].
- Geometry: stream one frame with tready=1 -> 8 beats; tlast on beats 3 and 7; addresses 0..7; 13 cycles between frame_done pulses.
- Backpressure: hold tready=0 for 20 cycles mid-line -> exactly 4 beats are buffered, rom_addr stalls, no data is lost or duplicated, and the beat sequence is unchanged after release.
- Sequencing: mode 0 with repeat_cnt=2 -> image_num runs 0,0,1,1,2,2,0 across frames. With repeat_cnt=0 -> it advances every frame.
- Step/hold: mode 2 with one step pulse mid-frame -> image_num advances once, at the next boundary only. In mode 1 it never changes.
- Reset mid-line: assert srst_p while 3 beats are buffered -> tvalid=0 and image_num=0 in the next cycle; a clean frame from pixel 0 follows once enable is reasserted.

Source files
------------

// File: rtl/pseudo_sensor_axis_src_if.sv
// rtl/pseudo_sensor_axis_src_if.sv - video stream bundle between the pseudo-sensor source and its sink
interface pseudo_sensor_axis_src_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tuser;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/pseudo_sensor_axis_src.sv
// rtl/pseudo_sensor_axis_src.sv - raster-scans a bank of image ROMs into a backpressured video stream
module pseudo_sensor_axis_src #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int H_BLANK    = 160,
   parameter int V_BLANK    = 45,
   parameter int ADDR_FRAME = 19,
   parameter int DATA_WIDTH = 8,
   parameter int N_IMAGES   = 10,
   parameter int IMG_W      = 4
) (
   input  logic                   p_clk,
   input  logic                   srst_p,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic                   step,
   input  logic [7:0]             repeat_cnt,
   output logic [ADDR_FRAME-1:0]  rom_addr,
   output logic [IMG_W-1:0]       rom_sel,
   input  logic [DATA_WIDTH-1:0]  rom_data,
   pseudo_sensor_axis_src_if.master m_axis,
   output logic [IMG_W-1:0]       image_num,
   output logic                   frame_done,
   output logic                   busy
);
   localparam int X_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int B_W  = (BMAX > 1) ? $clog2(BMAX) : 1;

   localparam logic [X_W-1:0]   X_LAST   = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_ACTIVE - 1);
   localparam logic [B_W-1:0]   HB_LAST  = B_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
   localparam logic [B_W-1:0]   VB_LAST  = B_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);
   localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(N_IMAGES - 1);

   typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;

   state_t                state, state_next;
   logic [X_W-1:0]        x;
   logic [Y_W-1:0]        y;
   logic [ADDR_FRAME-1:0] addr;
   logic [B_W-1:0]        blank_cnt;
   logic [7:0]            frame_cnt;
   logic                  step_pending;
   logic                  issue, issue_ok, line_end, boundary;
   logic                  inflight, tuser_d, tlast_d;
   logic [2:0]            fifo_count, occupancy;
   logic [1:0]            wr_ptr, rd_ptr;
   logic [DATA_WIDTH+1:0] fifo_mem [4];
   logic [DATA_WIDTH+1:0] head;
   logic                  pop;
   logic [7:0]            rep_eff;
   logic                  repeat_hit, advance, seq_consume;
   logic [IMG_W-1:0]      next_img;

   // Credit counts the read still in the ROM pipeline; a same-cycle pop is deliberately ignored.
   assign occupancy = fifo_count + {2'b00, inflight};
   assign issue_ok  = (occupancy < 3'd4);

   always_ff @(posedge p_clk) begin
      if (srst_p) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      line_end   = 1'b0;
      boundary   = 1'b0;
      case (state)
         IDLE:   if (enable) state_next = LINE;
         LINE: begin
            if (issue_ok) begin
               issue = 1'b1;
               if (x == X_LAST) begin
                  line_end = 1'b1;
                  if (y != Y_LAST) state_next = (H_BLANK == 0) ? LINE : HBLANK;
                  else             state_next = VBLANK;
               end
            end
         end
         HBLANK: if (blank_cnt == HB_LAST) state_next = LINE;
         VBLANK: begin
            if (blank_cnt == VB_LAST) begin
               boundary   = 1'b1;
               state_next = enable ? LINE : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (srst_p) begin
         x         <= '0;
         y         <= '0;
         addr      <= '0;
         blank_cnt <= '0;
         inflight  <= 1'b0;
         tuser_d   <= 1'b0;
         tlast_d   <= 1'b0;
      end else begin
         inflight <= issue;
         tuser_d  <= issue & (x == '0) & (y == '0);
         tlast_d  <= issue & line_end;
         if (state == IDLE || boundary) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
         end else if (issue) begin
            addr <= addr + ADDR_FRAME'(1);
            if (line_end) begin
               x <= '0;
               if (y != Y_LAST) y <= y + Y_W'(1);
            end else begin
               x <= x + X_W'(1);
            end
         end
         if ((state == HBLANK || state == VBLANK) && state_next == state)
            blank_cnt <= blank_cnt + B_W'(1);
         else
            blank_cnt <= '0;
      end
   end

   assign rep_eff     = (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
   assign repeat_hit  = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, rep_eff};
   assign advance     = (mode == 2'd0) || ((mode == 2'd2) && (step_pending || step));
   assign seq_consume = boundary && repeat_hit && (mode == 2'd2);
   assign next_img    = (image_num == IMG_LAST) ? '0 : image_num + IMG_W'(1);

   always_ff @(posedge p_clk) begin
      if (srst_p) begin
         frame_cnt    <= '0;
         image_num    <= '0;
         step_pending <= 1'b0;
      end else begin
         if (seq_consume) step_pending <= 1'b0;
         else if (step)   step_pending <= 1'b1;
         if (boundary) begin
            if (repeat_hit) begin
               frame_cnt <= '0;
               if (advance) image_num <= next_img;
            end else begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

   assign pop = m_axis.tvalid & m_axis.tready;

   always_ff @(posedge p_clk) begin
      if (srst_p) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      end else begin
         if (inflight) begin
            fifo_mem[wr_ptr] <= {rom_data, tuser_d, tlast_d};
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         fifo_count <= fifo_count + {2'b00, inflight} - {2'b00, pop};
      end
   end

   assign head          = fifo_mem[rd_ptr];
   assign m_axis.tvalid = (fifo_count != 3'd0);
   assign m_axis.tdata  = m_axis.tvalid ? head[DATA_WIDTH+1:2] : '0;
   assign m_axis.tuser  = m_axis.tvalid & head[1];
   assign m_axis.tlast  = m_axis.tvalid & head[0];

   assign rom_addr   = addr;
   assign rom_sel    = image_num;
   assign frame_done = boundary;
   assign busy       = (state != IDLE);
endmodule
